// File: rtl/imem_ctrl.sv
// imem_ctrl: instruction-memory responder for the fetch stage.
//
// Each cycle the fetch stage presents next_pc; the word at that address is
// returned one or more cycles later. Addresses inside the ITCM window are
// served from a synchronous ITCM with one-cycle latency. All other addresses
// are fetched over a req/gnt/rvalid instruction bus with one transaction
// outstanding at a time. A hold register replays the last bus word while
// fetch stalls on the same address.
//
// Optional feature: define KRV_IMEM_PREFETCH_EN to add a one-entry sequential
// prefetch buffer. After a demand word at A is delivered, the bus fetches A+4
// speculatively if the bus is otherwise idle. Without the macro the bus is
// demand-only and no prefetch state exists.

module imem_ctrl #(
    parameter int unsigned           ADDR_WIDTH  = 32,
    parameter int unsigned           INSTR_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] ITCM_BASE   = 32'h0000_0000,
    parameter logic [ADDR_WIDTH-1:0] ITCM_SIZE   = 32'h0001_0000,
    parameter int unsigned           ITCM_AW     = 14
) (
    input  logic                   cpu_clk,
    input  logic                   cpu_rstn,

    input  logic [ADDR_WIDTH-1:0]  boot_addr,
    input  logic [ADDR_WIDTH-1:0]  next_pc,
    input  logic                   imem_flush,

    output logic                   instr_read_data_valid,
    output logic [INSTR_WIDTH-1:0] instr_read_data,
    output logic                   instr_fault,

    output logic                   itcm_rd_en,
    output logic [ITCM_AW-1:0]     itcm_addr,
    input  logic [INSTR_WIDTH-1:0] itcm_rdata,

    output logic                   ib_req,
    output logic [ADDR_WIDTH-1:0]  ib_addr,
    input  logic                   ib_gnt,
    input  logic                   ib_rvalid,
    input  logic [INSTR_WIDTH-1:0] ib_rdata,
    input  logic                   ib_err
);

    localparam logic [ADDR_WIDTH-1:0] ITCM_MASK = ~(ITCM_SIZE - ADDR_WIDTH'(1));
    localparam logic [ADDR_WIDTH-1:0] WORD_STEP = ADDR_WIDTH'(4);

    typedef enum logic [1:0] {
        BUS_IDLE,
        BUS_REQ,
        BUS_WAIT
    } bus_state_t;

    function automatic logic in_itcm(input logic [ADDR_WIDTH-1:0] a);
        return (a & ITCM_MASK) == ITCM_BASE;
    endfunction

    // Fetch-side state
    logic [ADDR_WIDTH-1:0]  cur_pc;
    logic                   itcm_hit_r;

    // Hold register: last word delivered from the bus (or prefetch buffer)
    logic                   hold_v;
    logic [ADDR_WIDTH-1:0]  hold_addr;
    logic [INSTR_WIDTH-1:0] hold_data;
    logic                   hold_err;

    // Bus transaction state
    bus_state_t             bus_state;
    logic [ADDR_WIDTH-1:0]  req_addr;

    // Prefetch view; tied off when the feature is not built
    logic                   pf_v;
    logic [ADDR_WIDTH-1:0]  pf_addr;
    logic [INSTR_WIDTH-1:0] pf_data;
    logic                   pf_hit;
    logic                   pf_issue;
    logic [ADDR_WIDTH-1:0]  pf_req_addr;

    // Decode
    logic                   cur_in_itcm;
    logic                   hold_hit;
    logic                   need;
    logic                   issue_demand;
    logic                   bus_issue;
    logic [ADDR_WIDTH-1:0]  issue_addr;
    logic                   rsp_fire;
    logic                   rsp_match;

    assign cur_in_itcm  = in_itcm(cur_pc);
    assign hold_hit     = hold_v && (hold_addr == cur_pc) && !cur_in_itcm;
    assign need         = !cur_in_itcm && !hold_hit && !pf_hit;
    assign issue_demand = (bus_state == BUS_IDLE) && need;
    assign bus_issue    = issue_demand || pf_issue;
    assign issue_addr   = issue_demand ? cur_pc : pf_req_addr;
    assign rsp_fire     = (bus_state == BUS_WAIT) && ib_rvalid;
    // A response is only usable if fetch is still sitting on its address.
    assign rsp_match    = rsp_fire && (req_addr == cur_pc) && !cur_in_itcm;

    assign itcm_rd_en   = in_itcm(next_pc);
    assign itcm_addr    = next_pc[ITCM_AW+1:2];

    // Track the fetch PC and whether the ITCM was read for it
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            cur_pc     <= boot_addr;
            itcm_hit_r <= 1'b0;
        end else begin
            cur_pc     <= next_pc;
            itcm_hit_r <= itcm_rd_en;
        end
    end

`ifdef KRV_IMEM_PREFETCH_EN
    logic                  pf_arm;
    logic [ADDR_WIDTH-1:0] pf_arm_addr;
    logic                  req_is_pf;
    logic                  pf_kill;
    logic                  pf_fill;

    assign pf_hit      = pf_v && (pf_addr == cur_pc) && !cur_in_itcm;
    assign pf_req_addr = pf_arm_addr;
    // Prefetch only when no demand miss is waiting and the word is not already buffered.
    assign pf_issue    = (bus_state == BUS_IDLE) && !need && pf_arm &&
                         !in_itcm(pf_arm_addr) && !(pf_v && (pf_addr == pf_arm_addr));
    // Keep a prefetched word only if fetch is still one word behind it.
    assign pf_fill     = rsp_fire && req_is_pf && !pf_kill && !imem_flush && !ib_err &&
                         !rsp_match && (req_addr == cur_pc + WORD_STEP);

    // One-shot arm for the sequential successor of a delivered bus word
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            pf_arm      <= 1'b0;
            pf_arm_addr <= '0;
        end else begin
            pf_arm      <= rsp_match && !ib_err;
            pf_arm_addr <= req_addr + WORD_STEP;
        end
    end

    // Remember whether the outstanding transaction is speculative and flushed
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            req_is_pf <= 1'b0;
            pf_kill   <= 1'b0;
        end else if (bus_state == BUS_IDLE) begin
            if (bus_issue) begin
                req_is_pf <= pf_issue && !issue_demand;
                pf_kill   <= 1'b0;
            end
        end else if (imem_flush) begin
            pf_kill <= 1'b1;
        end
    end

    // Prefetch buffer: filled by a kept prefetch, consumed on hit, cleared by flush
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            pf_v    <= 1'b0;
            pf_addr <= '0;
            pf_data <= '0;
        end else if (imem_flush) begin
            pf_v <= 1'b0;
        end else if (pf_fill) begin
            pf_v    <= 1'b1;
            pf_addr <= req_addr;
            pf_data <= ib_rdata;
        end else if (pf_hit) begin
            pf_v <= 1'b0;
        end
    end
`else
    assign pf_v        = 1'b0;
    assign pf_addr     = '0;
    assign pf_data     = '0;
    assign pf_hit      = 1'b0;
    assign pf_issue    = 1'b0;
    assign pf_req_addr = '0;
`endif

    // Hold register: capture delivered bus words and consumed prefetch words
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            hold_v    <= 1'b0;
            hold_addr <= '0;
            hold_data <= '0;
            hold_err  <= 1'b0;
        end else if (imem_flush) begin
            hold_v <= 1'b0;
        end else if (rsp_match) begin
            hold_v    <= 1'b1;
            hold_addr <= req_addr;
            hold_data <= ib_rdata;
            hold_err  <= ib_err;
        end else if (pf_hit) begin
            hold_v    <= 1'b1;
            hold_addr <= pf_addr;
            hold_data <= pf_data;
            hold_err  <= 1'b0;
        end
    end

    // Bus FSM: one transaction in flight; a granted request always runs to rvalid
    always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
        if (!cpu_rstn) begin
            bus_state <= BUS_IDLE;
            req_addr  <= '0;
        end else begin
            unique case (bus_state)
                BUS_IDLE: begin
                    if (bus_issue) begin
                        req_addr  <= issue_addr;
                        bus_state <= ib_gnt ? BUS_WAIT : BUS_REQ;
                    end
                end
                BUS_REQ: begin
                    if (ib_gnt) begin
                        bus_state <= BUS_WAIT;
                    end
                end
                BUS_WAIT: begin
                    if (ib_rvalid) begin
                        bus_state <= BUS_IDLE;
                    end
                end
                default: bus_state <= BUS_IDLE;
            endcase
        end
    end

    // Bus request: issued from IDLE in the cycle of the miss, held stable in REQ
    always_comb begin
        ib_req  = 1'b0;
        ib_addr = '0;
        if (cpu_rstn) begin
            if (bus_state == BUS_REQ) begin
                ib_req  = 1'b1;
                ib_addr = req_addr;
            end else if (bus_issue) begin
                ib_req  = 1'b1;
                ib_addr = issue_addr;
            end
        end
        ib_addr[1:0] = 2'b00;
    end

    // Response mux: ITCM > hold > prefetch > live bus response
    always_comb begin
        instr_read_data_valid = 1'b0;
        instr_read_data       = '0;
        instr_fault           = 1'b0;
        if (itcm_hit_r) begin
            instr_read_data_valid = 1'b1;
            instr_read_data       = itcm_rdata;
        end else if (hold_hit) begin
            instr_read_data_valid = 1'b1;
            instr_read_data       = hold_data;
            instr_fault           = hold_err;
        end else if (pf_hit) begin
            instr_read_data_valid = 1'b1;
            instr_read_data       = pf_data;
        end else if (rsp_match) begin
            instr_read_data_valid = 1'b1;
            instr_read_data       = ib_rdata;
            instr_fault           = ib_err;
        end
    end

endmodule

// File: tb/tb_imem_ctrl.sv
// Directed bench for imem_ctrl: ITCM stream, bus miss, stall replay, redirect,
// bus error, reset mid-transaction, REQ stability and (when built) prefetch.
module tb_imem_ctrl;

    localparam logic [31:0] A0 = 32'h8000_0000;

    logic        cpu_clk = 1'b0;
    logic        cpu_rstn;
    logic [31:0] boot_addr;
    logic [31:0] next_pc;
    logic        imem_flush;
    logic        instr_read_data_valid;
    logic [31:0] instr_read_data;
    logic        instr_fault;
    logic        itcm_rd_en;
    logic [13:0] itcm_addr;
    logic [31:0] itcm_rdata;
    logic        ib_req;
    logic [31:0] ib_addr;
    logic        ib_gnt;
    logic        ib_rvalid;
    logic [31:0] ib_rdata;
    logic        ib_err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] data;
        logic        fault;
    } exp_t;
    exp_t sb[$];

    imem_ctrl #(
        .ADDR_WIDTH (32),
        .INSTR_WIDTH(32),
        .ITCM_BASE  (32'h0000_0000),
        .ITCM_SIZE  (32'h0001_0000),
        .ITCM_AW    (14)
    ) dut (
        .cpu_clk              (cpu_clk),
        .cpu_rstn             (cpu_rstn),
        .boot_addr            (boot_addr),
        .next_pc              (next_pc),
        .imem_flush           (imem_flush),
        .instr_read_data_valid(instr_read_data_valid),
        .instr_read_data      (instr_read_data),
        .instr_fault          (instr_fault),
        .itcm_rd_en           (itcm_rd_en),
        .itcm_addr            (itcm_addr),
        .itcm_rdata           (itcm_rdata),
        .ib_req               (ib_req),
        .ib_addr              (ib_addr),
        .ib_gnt               (ib_gnt),
        .ib_rvalid            (ib_rvalid),
        .ib_rdata             (ib_rdata),
        .ib_err               (ib_err)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Synchronous ITCM model
    logic [31:0] itcm_mem [0:16383];
    always @(posedge cpu_clk) begin
        if (itcm_rd_en) itcm_rdata <= itcm_mem[itcm_addr];
    end

    function automatic logic [31:0] itcm_word(input int i);
        return 32'h1000_0000 + 32'(i) * 32'h0000_0101;
    endfunction

    task automatic tick();
        @(posedge cpu_clk);
        #1;
    endtask

    task automatic sample();
        @(negedge cpu_clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [31:0] data, input logic fault);
        exp_t e;
        e.data  = data;
        e.fault = fault;
        sb.push_back(e);
    endtask

    // Compare the response port against the scoreboard head
    task automatic chk_out(input string tag, input logic exp_valid);
        exp_t e;
        chk({tag, "_valid"}, 32'(instr_read_data_valid), 32'(exp_valid));
        if (exp_valid) begin
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL %s_sb: observed empty scoreboard expected an entry", tag);
            end else begin
                e = sb.pop_front();
                chk({tag, "_data"}, instr_read_data, e.data);
                chk({tag, "_fault"}, 32'(instr_fault), 32'(e.fault));
            end
        end else begin
            chk({tag, "_data0"}, instr_read_data, 32'h0);
        end
    endtask

    task automatic chk_bus(input string tag, input logic exp_req, input logic [31:0] exp_addr);
        chk({tag, "_req"}, 32'(ib_req), 32'(exp_req));
        if (exp_req) chk({tag, "_addr"}, ib_addr, exp_addr);
    endtask

    // Reset with bus idle; cur_pc takes next_pc = pc at the first edge after release
    task automatic do_reset(input logic [31:0] pc);
        cpu_rstn   = 1'b0;
        next_pc    = pc;
        imem_flush = 1'b0;
        ib_gnt     = 1'b0;
        ib_rvalid  = 1'b0;
        ib_rdata   = 32'h0;
        ib_err     = 1'b0;
        @(posedge cpu_clk);
        @(negedge cpu_clk);
        cpu_rstn = 1'b1;
    endtask

`ifdef KRV_IMEM_PREFETCH_EN
    // Demand A0, deliver it, then let the prefetch of A0+4 complete while fetch stalls
    task automatic pf_prefix(input logic [31:0] pf_word);
        do_reset(A0);
        tick(); ib_gnt = 1'b1;
        sample(); chk_bus("pf_dem", 1'b1, A0);
        tick(); ib_gnt = 1'b0; ib_rvalid = 1'b1; ib_rdata = 32'h0000_0013;
        push(32'h0000_0013, 1'b0);
        sample(); chk_out("pf_dem_rsp", 1'b1);
        tick(); ib_rvalid = 1'b0; ib_gnt = 1'b1;
        push(32'h0000_0013, 1'b0);
        sample(); chk_out("pf_stall", 1'b1); chk_bus("pf_issue", 1'b1, A0 + 32'h4);
        tick(); ib_gnt = 1'b0; ib_rvalid = 1'b1; ib_rdata = pf_word;
        push(32'h0000_0013, 1'b0);
        sample(); chk_out("pf_fill", 1'b1);
        tick(); ib_rvalid = 1'b0;
    endtask
`endif

    initial begin
        for (int i = 0; i < 16384; i++) itcm_mem[i] = itcm_word(i);

        // Reset state with boot_addr = 0
        boot_addr  = 32'h0;
        cpu_rstn   = 1'b0;
        next_pc    = 32'h0;
        imem_flush = 1'b0;
        ib_gnt     = 1'b0;
        ib_rvalid  = 1'b0;
        ib_rdata   = 32'h0;
        ib_err     = 1'b0;
        repeat (2) @(posedge cpu_clk);
        sample();
        chk("rst_valid", 32'(instr_read_data_valid), 32'h0);
        chk("rst_fault", 32'(instr_fault), 32'h0);
        chk("rst_data", instr_read_data, 32'h0);
        chk("rst_req", 32'(ib_req), 32'h0);
        chk("rst_addr", ib_addr, 32'h0);

        // ITCM stream: next_pc 0,4,8 gives words 0,1,2 in cycles 1,2,3
        push(itcm_word(0), 1'b0);
        cpu_rstn = 1'b1;
        tick(); next_pc = 32'h4; push(itcm_word(1), 1'b0);
        sample(); chk_out("itcm0", 1'b1); chk_bus("itcm0", 1'b0, 32'h0);
        tick(); next_pc = 32'h8; push(itcm_word(2), 1'b0);
        sample(); chk_out("itcm1", 1'b1); chk_bus("itcm1", 1'b0, 32'h0);
        tick(); next_pc = A0;
        sample(); chk_out("itcm2", 1'b1); chk_bus("itcm2", 1'b0, 32'h0);

        // Bus miss: grant two cycles after the first request, rvalid three after grant
        tick();
        sample(); chk_out("miss_q0", 1'b0); chk_bus("miss_q0", 1'b1, A0);
        tick();
        sample(); chk_out("miss_q1", 1'b0); chk_bus("miss_q1", 1'b1, A0);
        tick(); ib_gnt = 1'b1;
        sample(); chk_out("miss_gnt", 1'b0); chk_bus("miss_gnt", 1'b1, A0);
        tick(); ib_gnt = 1'b0;
        sample(); chk_out("miss_w1", 1'b0); chk_bus("miss_w1", 1'b0, 32'h0);
        tick();
        sample(); chk_out("miss_w2", 1'b0);
        tick(); ib_rvalid = 1'b1; ib_rdata = 32'h0000_0013; push(32'h0000_0013, 1'b0);
        sample(); chk_out("miss_rsp", 1'b1);

        // Fetch stall: hold register replays the word with no demand traffic
        for (int i = 0; i < 3; i++) begin
            tick(); ib_rvalid = 1'b0; ib_rdata = 32'hFFFF_FFFF; push(32'h0000_0013, 1'b0);
            sample(); chk_out("stall", 1'b1);
`ifdef KRV_IMEM_PREFETCH_EN
            chk_bus("stall_pf", 1'b1, A0 + 32'h4);
`else
            chk_bus("stall", 1'b0, 32'h0);
`endif
        end

        // Redirect while in WAIT: stale response dropped, new request the next cycle
        do_reset(A0);
        tick(); ib_gnt = 1'b1;
        sample(); chk_out("redir_req", 1'b0); chk_bus("redir_req", 1'b1, A0);
        tick(); ib_gnt = 1'b0; next_pc = A0 + 32'h100;
        sample(); chk_out("redir_wait", 1'b0); chk_bus("redir_wait", 1'b0, 32'h0);
        tick(); ib_rvalid = 1'b1; ib_rdata = 32'hDEAD_BEEF;
        sample(); chk_out("stale", 1'b0); chk_bus("stale", 1'b0, 32'h0);
        tick(); ib_rvalid = 1'b0; ib_gnt = 1'b1;
        sample(); chk_out("reissue", 1'b0); chk_bus("reissue", 1'b1, A0 + 32'h100);

        // Bus error on the current address, then replayed from the hold register
        tick(); ib_gnt = 1'b0; ib_rvalid = 1'b1; ib_rdata = 32'h0000_0093; ib_err = 1'b1;
        push(32'h0000_0093, 1'b1);
        sample(); chk_out("buserr", 1'b1);
        tick(); ib_rvalid = 1'b0; ib_err = 1'b0; next_pc = A0 + 32'h200;
        push(32'h0000_0093, 1'b1);
        sample(); chk_out("err_hold", 1'b1); chk_bus("err_hold", 1'b0, 32'h0);

        // Reset mid-transaction, then a late rvalid in IDLE is ignored
        tick(); ib_gnt = 1'b1;
        sample(); chk_out("mid_req", 1'b0); chk_bus("mid_req", 1'b1, A0 + 32'h200);
        tick(); ib_gnt = 1'b0; cpu_rstn = 1'b0;
        sample(); chk_out("mid_rst", 1'b0); chk_bus("mid_rst", 1'b0, 32'h0);
        chk("mid_rst_addr", ib_addr, 32'h0);
        cpu_rstn = 1'b1;
        tick(); ib_rvalid = 1'b1; ib_rdata = 32'h0BAD_0BAD;
        sample(); chk_out("late_rvalid", 1'b0); chk_bus("late_rvalid", 1'b1, A0 + 32'h200);

        // REQ holds its address while fetch redirects
        tick(); ib_rvalid = 1'b0; next_pc = A0 + 32'h300;
        sample(); chk_out("req_hold0", 1'b0); chk_bus("req_hold0", 1'b1, A0 + 32'h200);
        tick();
        sample(); chk_out("req_hold1", 1'b0); chk_bus("req_hold1", 1'b1, A0 + 32'h200);

`ifdef KRV_IMEM_PREFETCH_EN
        // Prefetch hit: advance after the prefetched word has returned
        pf_prefix(32'h0040_0113);
        next_pc = A0 + 32'h4; push(32'h0000_0013, 1'b0);
        sample(); chk_out("pf_adv", 1'b1);
        tick(); push(32'h0040_0113, 1'b0);
        sample(); chk_out("pf_hit", 1'b1); chk_bus("pf_hit", 1'b0, 32'h0);
        tick(); push(32'h0040_0113, 1'b0);
        sample(); chk_out("pf_hold", 1'b1); chk_bus("pf_hold", 1'b0, 32'h0);

        // Flush before the advance forces a demand request
        pf_prefix(32'h0050_0193);
        next_pc = A0 + 32'h4; imem_flush = 1'b1; push(32'h0000_0013, 1'b0);
        sample(); chk_out("flush_adv", 1'b1);
        tick(); imem_flush = 1'b0;
        sample(); chk_out("flush_miss", 1'b0); chk_bus("flush_miss", 1'b1, A0 + 32'h4);
`endif

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
